avalon_mm_cmd_master: RTL and testbench

AVALON_MM_CMD_MASTER -- requirements
Module: avalon_mm_cmd_master

---
 rtl/avalon_mm_pkg.sv | 23 ++
 rtl/avalon_mm_cmd_master.sv | 141 ++++++++++++++
 tb/tb_avalon_mm_cmd_master.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_mm_pkg.sv
// Shared types for the Avalon-MM command master: FSM states and the
// registered command record.
package avalon_mm_pkg;

  // Widest address/data the command record can carry; instances narrower
  // than this zero-extend into it.
  localparam int unsigned CMD_ADDR_W_MAX = 32;
  localparam int unsigned CMD_DATA_W_MAX = 64;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RDLAT,
    RESP
  } state_t;

  typedef struct packed {
    logic                      write;
    logic [CMD_ADDR_W_MAX-1:0] address;
    logic [CMD_DATA_W_MAX-1:0] writedata;
  } cmd_t;

endpackage

// File: rtl/avalon_mm_cmd_master.sv
// Single-outstanding Avalon-MM master: takes one command, runs one bus
// transfer with waitrequest timeout and fixed read latency, returns one response.
module avalon_mm_cmd_master
  import avalon_mm_pkg::*;
#(
  parameter int ADDR_W   = 2,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 0,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_writedata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_readdata,
  output logic              rsp_timeout,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic              avm_read_n,
  output logic [ADDR_W-1:0] avm_address,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest
);

  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [1:0]  LAT_LAST = (READ_LAT > 0) ? 2'(READ_LAT - 1) : 2'd0;

  state_t            state, state_next;
  cmd_t              cmd_q, cmd_next;
  logic [15:0]       wait_cnt, wait_cnt_next;
  logic [1:0]        lat_cnt, lat_cnt_next;
  logic [DATA_W-1:0] rdata_q, rdata_next;
  logic              timeout_q, timeout_next;

  // Upper bits of the zero-extended command record are never read back.
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^cmd_q;

  // NOTE: every register, command record included, is reset so the bus
  // address/data outputs come up as 0; state uses non-blocking updates only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cmd_q     <= '0;
      wait_cnt  <= '0;
      lat_cnt   <= '0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_next;
      cmd_q     <= cmd_next;
      wait_cnt  <= wait_cnt_next;
      lat_cnt   <= lat_cnt_next;
      rdata_q   <= rdata_next;
      timeout_q <= timeout_next;
    end
  end

  // NOTE: all outputs of this block get a default first so no path infers a latch.
  always_comb begin
    state_next     = state;
    cmd_next       = cmd_q;
    wait_cnt_next  = wait_cnt;
    lat_cnt_next   = lat_cnt;
    rdata_next     = rdata_q;
    timeout_next   = timeout_q;
    cmd_ready      = 1'b0;
    rsp_valid      = 1'b0;
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_read_n     = 1'b1;

    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cmd_next.write     = cmd_write;
          cmd_next.address   = CMD_ADDR_W_MAX'(cmd_address);
          cmd_next.writedata = CMD_DATA_W_MAX'(cmd_writedata);
          wait_cnt_next      = '0;
          state_next         = BUS;
        end
      end

      BUS: begin
        avm_chipselect = 1'b1;
        avm_write_n    = ~cmd_q.write;
        avm_read_n     = cmd_q.write;
        if (!avm_waitrequest) begin
          timeout_next = 1'b0;
          if (cmd_q.write) begin
            rdata_next = '0;
            state_next = RESP;
          end else if (READ_LAT == 0) begin
            rdata_next = avm_readdata;
            state_next = RESP;
          end else begin
            lat_cnt_next = '0;
            state_next   = RDLAT;
          end
        end else begin
          // Saturating stall count; the cycle that brings it to TIMEOUT aborts.
          if (wait_cnt != 16'hFFFF) wait_cnt_next = wait_cnt + 16'd1;
          if (wait_cnt >= TO_LAST) begin
            rdata_next   = '0;
            timeout_next = 1'b1;
            state_next   = RESP;
          end
        end
      end

      RDLAT: begin
        if (lat_cnt == LAT_LAST) begin
          rdata_next = avm_readdata;
          state_next = RESP;
        end else begin
          lat_cnt_next = lat_cnt + 2'd1;
        end
      end

      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign avm_address   = cmd_q.address[ADDR_W-1:0];
  assign avm_writedata = cmd_q.writedata[DATA_W-1:0];
  assign rsp_readdata  = rdata_q;
  assign rsp_timeout   = timeout_q;

endmodule

// File: tb/tb_avalon_mm_cmd_master.sv
// Directed bench: instance A (READ_LAT=0) talks to a PIO-like register model,
// instance B (READ_LAT=2, TIMEOUT=4) to a directly driven slave.
module tb_avalon_mm_cmd_master;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic        a_cmd_valid, a_cmd_ready, a_cmd_write, a_rsp_valid, a_rsp_ready, a_rsp_timeout;
  logic [1:0]  a_cmd_address, a_addr;
  logic [31:0] a_cmd_writedata, a_rsp_readdata, a_wdata, a_rdata;
  logic        a_cs, a_write_n, a_read_n, a_wait;

  logic        b_cmd_valid, b_cmd_ready, b_cmd_write, b_rsp_valid, b_rsp_ready, b_rsp_timeout;
  logic [1:0]  b_cmd_address, b_addr;
  logic [31:0] b_cmd_writedata, b_rsp_readdata, b_wdata, b_rdata;
  logic        b_cs, b_write_n, b_read_n, b_wait;

  avalon_mm_cmd_master #(.ADDR_W(2), .DATA_W(32), .READ_LAT(0), .TIMEOUT(255)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_write(a_cmd_write),
    .cmd_address(a_cmd_address), .cmd_writedata(a_cmd_writedata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_readdata(a_rsp_readdata), .rsp_timeout(a_rsp_timeout),
    .avm_chipselect(a_cs), .avm_write_n(a_write_n), .avm_read_n(a_read_n),
    .avm_address(a_addr), .avm_writedata(a_wdata),
    .avm_readdata(a_rdata), .avm_waitrequest(a_wait)
  );

  avalon_mm_cmd_master #(.ADDR_W(2), .DATA_W(32), .READ_LAT(2), .TIMEOUT(4)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(b_cmd_write),
    .cmd_address(b_cmd_address), .cmd_writedata(b_cmd_writedata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_readdata(b_rsp_readdata), .rsp_timeout(b_rsp_timeout),
    .avm_chipselect(b_cs), .avm_write_n(b_write_n), .avm_read_n(b_read_n),
    .avm_address(b_addr), .avm_writedata(b_wdata),
    .avm_readdata(b_rdata), .avm_waitrequest(b_wait)
  );

  // PIO-like slave: word 0 is the output register, other words read as 0.
  logic [31:0] out_port = '0;
  int          a_done = 0;
  assign a_rdata = (a_addr == 2'd0) ? out_port : 32'd0;
  always @(posedge clk) begin
    if (a_cs && !a_write_n && !a_wait) begin
      a_done <= a_done + 1;
      if (a_addr == 2'd0) out_port <= a_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_issue(input logic w, input logic [1:0] ad, input logic [31:0] d);
    a_cmd_valid = 1'b1; a_cmd_write = w; a_cmd_address = ad; a_cmd_writedata = d;
    tick();
    a_cmd_valid = 1'b0;
  endtask

  task automatic b_issue(input logic w, input logic [1:0] ad, input logic [31:0] d);
    b_cmd_valid = 1'b1; b_cmd_write = w; b_cmd_address = ad; b_cmd_writedata = d;
    tick();
    b_cmd_valid = 1'b0;
  endtask

  task automatic a_take_rsp();
    a_rsp_ready = 1'b1;
    tick();
    a_rsp_ready = 1'b0;
  endtask

  task automatic b_take_rsp();
    b_rsp_ready = 1'b1;
    tick();
    b_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    total++; if ({a_cmd_ready, a_rsp_valid, a_rsp_timeout} !== 3'b100) begin bad++;
      $display("FAIL reset_handshake: got %b want 100", {a_cmd_ready, a_rsp_valid, a_rsp_timeout}); end
    total++; if ({a_cs, a_write_n, a_read_n} !== 3'b011) begin bad++;
      $display("FAIL reset_strobes: got %b want 011", {a_cs, a_write_n, a_read_n}); end
    total++; if ({a_addr, a_wdata, a_rsp_readdata} !== 66'd0) begin bad++;
      $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h want 0", a_addr, a_wdata, a_rsp_readdata); end
    total++; if ({b_cmd_ready, b_rsp_valid, b_cs, b_write_n, b_read_n} !== 5'b10011) begin bad++;
      $display("FAIL reset_b: got %b want 10011", {b_cmd_ready, b_rsp_valid, b_cs, b_write_n, b_read_n}); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_write();
    a_wait = 1'b0;
    a_issue(1'b1, 2'd0, 32'hDEADBEEF);
    total++; if ({a_cs, a_write_n, a_read_n, a_cmd_ready} !== 4'b1010) begin bad++;
      $display("FAIL write_bus: got %b want 1010", {a_cs, a_write_n, a_read_n, a_cmd_ready}); end
    total++; if ({a_addr, a_wdata} !== {2'd0, 32'hDEADBEEF}) begin bad++;
      $display("FAIL write_bus_data: got %h/%h want 0/deadbeef", a_addr, a_wdata); end
    tick();
    total++; if ({a_cs, a_write_n, a_read_n} !== 3'b011) begin bad++;
      $display("FAIL write_strobe_drop: got %b want 011", {a_cs, a_write_n, a_read_n}); end
    total++; if ({a_rsp_valid, a_rsp_timeout, a_rsp_readdata} !== {2'b10, 32'd0}) begin bad++;
      $display("FAIL write_rsp: got v=%b t=%b d=%h want 1 0 0", a_rsp_valid, a_rsp_timeout, a_rsp_readdata); end
    total++; if (out_port !== 32'hDEADBEEF) begin bad++;
      $display("FAIL write_out_port: got %h want deadbeef", out_port); end
    a_take_rsp();
    total++; if ({a_rsp_valid, a_cmd_ready} !== 2'b01) begin bad++;
      $display("FAIL write_rsp_done: got %b want 01", {a_rsp_valid, a_cmd_ready}); end
  endtask

  task automatic test_read();
    a_issue(1'b0, 2'd0, 32'h0);
    total++; if ({a_cs, a_write_n, a_read_n} !== 3'b110) begin bad++;
      $display("FAIL read_bus: got %b want 110", {a_cs, a_write_n, a_read_n}); end
    tick();
    total++; if ({a_rsp_valid, a_rsp_timeout, a_rsp_readdata} !== {2'b10, 32'hDEADBEEF}) begin bad++;
      $display("FAIL read_addr0: got v=%b t=%b d=%h want 1 0 deadbeef", a_rsp_valid, a_rsp_timeout, a_rsp_readdata); end
    a_take_rsp();
    a_issue(1'b0, 2'd1, 32'h0);
    tick();
    total++; if ({a_rsp_valid, a_rsp_readdata} !== {1'b1, 32'd0}) begin bad++;
      $display("FAIL read_addr1: got v=%b d=%h want 1 0", a_rsp_valid, a_rsp_readdata); end
    a_take_rsp();
  endtask

  task automatic test_waitrequest();
    int d0;
    d0 = a_done;
    a_wait = 1'b1;
    a_issue(1'b1, 2'd2, 32'hCAFEF00D);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) a_wait = 1'b0;
      total++; if ({a_cs, a_write_n, a_read_n, a_rsp_valid, a_addr, a_wdata} !== {4'b1010, 2'd2, 32'hCAFEF00D}) begin bad++;
        $display("FAIL wait_hold[%0d]: got cs/wn/rn/v=%b addr=%h data=%h want 1010 2 cafef00d",
                 i, {a_cs, a_write_n, a_read_n, a_rsp_valid}, a_addr, a_wdata); end
      tick();
    end
    total++; if ({a_cs, a_write_n, a_rsp_valid, a_rsp_timeout} !== 4'b0110) begin bad++;
      $display("FAIL wait_complete: got %b want 0110", {a_cs, a_write_n, a_rsp_valid, a_rsp_timeout}); end
    total++; if (a_done - d0 !== 1) begin bad++;
      $display("FAIL wait_one_completion: got %0d want 1", a_done - d0); end
    a_take_rsp();
  endtask

  task automatic test_timeout();
    b_wait = 1'b1;
    b_rdata = 32'hFFFFFFFF;
    b_issue(1'b1, 2'd1, 32'hA5A5A5A5);
    for (int i = 0; i < 4; i++) begin
      total++; if ({b_cs, b_write_n, b_read_n, b_rsp_valid, b_addr} !== {4'b1010, 2'd1}) begin bad++;
        $display("FAIL timeout_hold[%0d]: got %b want 1010 01", i, {b_cs, b_write_n, b_read_n, b_rsp_valid, b_addr}); end
      tick();
    end
    total++; if ({b_cs, b_write_n, b_read_n} !== 3'b011) begin bad++;
      $display("FAIL timeout_strobe_drop: got %b want 011", {b_cs, b_write_n, b_read_n}); end
    total++; if ({b_rsp_valid, b_rsp_timeout, b_rsp_readdata} !== {2'b11, 32'd0}) begin bad++;
      $display("FAIL timeout_write_rsp: got v=%b t=%b d=%h want 1 1 0", b_rsp_valid, b_rsp_timeout, b_rsp_readdata); end
    b_take_rsp();
    b_issue(1'b0, 2'd2, 32'h0);
    for (int i = 0; i < 4; i++) tick();
    total++; if ({b_rsp_valid, b_rsp_timeout, b_rsp_readdata, b_read_n} !== {2'b11, 32'd0, 1'b1}) begin bad++;
      $display("FAIL timeout_read_rsp: got v=%b t=%b d=%h rn=%b want 1 1 0 1", b_rsp_valid, b_rsp_timeout, b_rsp_readdata, b_read_n); end
    b_take_rsp();
    b_wait = 1'b0;
  endtask

  task automatic test_read_latency();
    int lat;
    b_rdata = 32'h0BAD0BAD;
    b_issue(1'b0, 2'd3, 32'h0);
    lat = 1;
    while (b_rsp_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
      b_rdata = (lat == 3) ? 32'h12345678 : 32'h0BAD0BAD;
      if (lat == 2) begin
        total++; if ({b_cs, b_read_n, b_rsp_valid} !== 3'b010) begin bad++;
          $display("FAIL rdlat_strobes: got %b want 010", {b_cs, b_read_n, b_rsp_valid}); end
      end
    end
    total++; if (lat !== 4) begin bad++;
      $display("FAIL rdlat_latency: got %0d cycles want 4", lat); end
    total++; if ({b_rsp_readdata, b_rsp_timeout} !== {32'h12345678, 1'b0}) begin bad++;
      $display("FAIL rdlat_data: got d=%h t=%b want 12345678 0", b_rsp_readdata, b_rsp_timeout); end
    b_take_rsp();
  endtask

  task automatic test_reset_mid();
    int d0;
    a_wait = 1'b1;
    d0 = a_done;
    a_issue(1'b1, 2'd0, 32'h11112222);
    total++; if (a_cs !== 1'b1) begin bad++;
      $display("FAIL midreset_in_bus: got cs=%b want 1", a_cs); end
    reset_n = 1'b0;
    #1;
    total++; if ({a_cmd_ready, a_rsp_valid, a_cs, a_write_n, a_read_n, a_addr, a_wdata} !== {5'b10011, 34'd0}) begin bad++;
      $display("FAIL midreset_outputs: got %b addr=%h data=%h want 10011 0 0",
               {a_cmd_ready, a_rsp_valid, a_cs, a_write_n, a_read_n}, a_addr, a_wdata); end
    #1;
    reset_n = 1'b1;
    a_wait = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if ({a_rsp_valid, a_cmd_ready, a_cs} !== 3'b010) begin bad++;
        $display("FAIL midreset_no_rsp[%0d]: got %b want 010", i, {a_rsp_valid, a_cmd_ready, a_cs}); end
    end
    total++; if ({out_port, a_done - d0} !== {32'hDEADBEEF, 32'd0}) begin bad++;
      $display("FAIL midreset_abandon: got out=%h done=%0d want deadbeef 0", out_port, a_done - d0); end

    a_issue(1'b0, 2'd0, 32'h0);
    tick();
    a_cmd_valid = 1'b1; a_cmd_write = 1'b1; a_cmd_address = 2'd0; a_cmd_writedata = 32'h55555555;
    for (int i = 0; i < 4; i++) begin
      total++; if ({a_rsp_valid, a_cmd_ready, a_cs, a_rsp_readdata} !== {3'b100, 32'hDEADBEEF}) begin bad++;
        $display("FAIL rsp_hold[%0d]: got v/rdy/cs=%b d=%h want 100 deadbeef", i, {a_rsp_valid, a_cmd_ready, a_cs}, a_rsp_readdata); end
      tick();
    end
    total++; if ({out_port, a_done - d0} !== {32'hDEADBEEF, 32'd0}) begin bad++;
      $display("FAIL rsp_hold_ignored_cmd: got out=%h done=%0d want deadbeef 0", out_port, a_done - d0); end
    a_cmd_valid = 1'b0;
    a_take_rsp();
    total++; if ({a_rsp_valid, a_cmd_ready} !== 2'b01) begin bad++;
      $display("FAIL rsp_hold_release: got %b want 01", {a_rsp_valid, a_cmd_ready}); end
  endtask

  initial begin
    a_cmd_valid = 1'b0; a_cmd_write = 1'b0; a_cmd_address = '0; a_cmd_writedata = '0;
    a_rsp_ready = 1'b0; a_wait = 1'b0;
    b_cmd_valid = 1'b0; b_cmd_write = 1'b0; b_cmd_address = '0; b_cmd_writedata = '0;
    b_rsp_ready = 1'b0; b_wait = 1'b0; b_rdata = '0;
    test_reset();
    test_write();
    test_read();
    test_waitrequest();
    test_timeout();
    test_read_latency();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
